// File: rtl/bus_periph_pkg.sv
// Shared definitions for the CPU-bus peripherals: register word offsets,
// STATUS bit positions and the UART transmitter state encoding.
package bus_periph_pkg;

  // Register offsets expressed as word indices (busAddr[3:2]).
  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_TXDATA  = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd2;
  localparam logic [1:0] ADDR_DROPCNT = 2'd3;

  // STATUS register bit positions.
  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_MSB = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
// Push is ignored when full and pop is ignored when empty, both judged on
// the state before the clock edge; rdata always shows the head entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage array: written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks push/pop balance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the single-cycle CPU data bus.
// Bytes written to TXDATA queue in a FIFO; a baud-timed FSM shifts them
// out LSB first. STATUS/CTRL/DROPCNT are polled through the same port.
module bus_uart_tx
  import bus_periph_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busSel,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  output logic [31:0] busRData,
  output logic        tx
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  logic [1:0]       reg_idx_s;
  logic             wr_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic [CW-1:0]    count_s;
  logic [7:0]       head_s;
  logic [31:0]      rdata_s;
  logic             unused_bits_s;

  logic             enable_r;
  logic [7:0]       dropcnt_r;

  uart_tx_state_e   state_r;
  uart_tx_state_e   state_n_s;
  logic [CNT_W-1:0] baud_cnt_r;
  logic [CNT_W-1:0] baud_cnt_n_s;
  logic [2:0]       bit_idx_r;
  logic [2:0]       bit_idx_n_s;
  logic [7:0]       shift_r;
  logic [7:0]       shift_n_s;
  logic             tx_r;
  logic             tx_n_s;

  assign reg_idx_s     = busAddr[3:2];
  assign wr_s          = busSel && busWe;
  assign push_s        = wr_s && (reg_idx_s == ADDR_TXDATA);
  assign unused_bits_s = ^{busAddr[31:4], busAddr[1:0], busWData[31:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (busWData[7:0]),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // CTRL register: only the enable bit is implemented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_r <= 1'b0;
    end else if (wr_s && (reg_idx_s == ADDR_CTRL)) begin
      enable_r <= busWData[0];
    end else begin
      enable_r <= enable_r;
    end
  end

  // Dropped-push counter: any write to its offset clears it, saturates at 255.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dropcnt_r <= 8'h00;
    end else if (wr_s && (reg_idx_s == ADDR_DROPCNT)) begin
      dropcnt_r <= 8'h00;
    end else if (push_s && full_s && (dropcnt_r != 8'hFF)) begin
      dropcnt_r <= dropcnt_r + 8'h01;
    end else begin
      dropcnt_r <= dropcnt_r;
    end
  end

  // Combinational read mux; deselected bus reads as zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (busSel) begin
      case (reg_idx_s)
        ADDR_STATUS: begin
          rdata_s[STAT_BUSY]                     = (state_r != IDLE);
          rdata_s[STAT_FULL]                     = full_s;
          rdata_s[STAT_EMPTY]                    = empty_s;
          rdata_s[STAT_COUNT_MSB:STAT_COUNT_LSB] = 8'(count_s);
        end
        ADDR_CTRL:    rdata_s[0]   = enable_r;
        ADDR_DROPCNT: rdata_s[7:0] = dropcnt_r;
        default:      rdata_s      = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign busRData = rdata_s;

  // Serialiser state register; tx is registered so reset forces it high at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      baud_cnt_r <= {CNT_W{1'b0}};
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      tx_r       <= 1'b1;
    end else begin
      state_r    <= state_n_s;
      baud_cnt_r <= baud_cnt_n_s;
      bit_idx_r  <= bit_idx_n_s;
      shift_r    <= shift_n_s;
      tx_r       <= tx_n_s;
    end
  end

  // Next-state logic: tx_n_s is the line level for the coming clock, so the
  // start bit appears from the same edge that pops the byte.
  always_comb begin
    state_n_s    = state_r;
    baud_cnt_n_s = baud_cnt_r;
    bit_idx_n_s  = bit_idx_r;
    shift_n_s    = shift_r;
    tx_n_s       = tx_r;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable_r && !empty_s) begin
          pop_s        = 1'b1;
          shift_n_s    = head_s;
          baud_cnt_n_s = {CNT_W{1'b0}};
          state_n_s    = START;
          tx_n_s       = 1'b0;
        end else begin
          tx_n_s       = 1'b1;
        end
      end
      START: begin
        if (baud_cnt_r == DIV_LAST) begin
          baud_cnt_n_s = {CNT_W{1'b0}};
          bit_idx_n_s  = 3'd0;
          state_n_s    = DATA;
          tx_n_s       = shift_r[0];
        end else begin
          baud_cnt_n_s = baud_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DATA: begin
        if (baud_cnt_r == DIV_LAST) begin
          baud_cnt_n_s = {CNT_W{1'b0}};
          if (bit_idx_r == 3'd7) begin
            state_n_s = STOP;
            tx_n_s    = 1'b1;
          end else begin
            bit_idx_n_s = bit_idx_r + 3'd1;
            shift_n_s   = {1'b0, shift_r[7:1]};
            tx_n_s      = shift_r[1];
          end
        end else begin
          baud_cnt_n_s = baud_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      STOP: begin
        if (baud_cnt_r == DIV_LAST) begin
          baud_cnt_n_s = {CNT_W{1'b0}};
          if (enable_r && !empty_s) begin
            pop_s     = 1'b1;
            shift_n_s = head_s;
            state_n_s = START;
            tx_n_s    = 1'b0;
          end else begin
            state_n_s = IDLE;
            tx_n_s    = 1'b1;
          end
        end else begin
          baud_cnt_n_s = baud_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_n_s    = IDLE;
        baud_cnt_n_s = {CNT_W{1'b0}};
        tx_n_s       = 1'b1;
      end
    endcase
  end

  assign tx = tx_r;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Scoreboard bench for bus_uart_tx with DIV=16: stimulus queues expected
// bytes, an independent line monitor decodes every frame on tx and checks
// it bit-by-bit against the queue.
module tb_bus_uart_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        busSel = 1'b0;
  logic        busWe = 1'b0;
  logic [31:0] busAddr = 32'h0;
  logic [31:0] busWData = 32'h0;
  logic [31:0] busRData;
  logic        tx;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  byte unsigned exp_q[$];
  int           starts_q[$];
  bit           mon_busy = 1'b0;

  bus_uart_tx #(
    .CLK_FREQ   (160_000),
    .BAUD       (10_000),
    .FIFO_DEPTH (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .busSel   (busSel),
    .busWe    (busWe),
    .busAddr  (busAddr),
    .busWData (busWData),
    .busRData (busRData),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  // Edge counter used to timestamp writes and frame starts.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int wc);
    @(negedge clk);
    busSel = 1'b1; busWe = 1'b1; busAddr = a; busWData = d;
    @(posedge clk);
    #1;
    wc = cyc;
    busSel = 1'b0; busWe = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    busSel = 1'b1; busWe = 1'b0; busAddr = a;
    #1;
    d = busRData;
    busSel = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_done(input int n, input int maxc, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (exp_q.size() == n && !mon_busy) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
    end
    check(name, {31'b0, done}, 32'd1);
  endtask

  // Line monitor: on a falling edge from idle, sample 160 clocks and compare
  // every clock with the 8N1 pattern of the next queued byte.
  initial begin : monitor
    logic       prev;
    logic [7:0] got;
    logic [9:0] pat;
    byte unsigned e;
    int         bad;
    bit         aborted;
    bit         have;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset && prev && !tx) begin
        mon_busy = 1'b1;
        starts_q.push_back(cyc);
        have = (exp_q.size() != 0);
        check("frame_expected", {31'b0, have}, 32'd1);
        e = have ? exp_q.pop_front() : 8'h00;
        pat = {1'b1, e, 1'b0};
        bad = 0; aborted = 1'b0; got = 8'h00;
        for (int i = 0; i < 160; i++) begin
          if (i > 0) @(negedge clk);
          if (!reset) begin
            aborted = 1'b1;
            break;
          end
          if (tx !== pat[i/16]) bad++;
          if ((i % 16) == 8 && i >= 16 && i < 144) got[(i/16)-1] = tx;
        end
        if (!aborted) begin
          check("frame_byte", {24'b0, got}, {24'b0, e});
          check("frame_bit_timing", 32'(bad), 32'd0);
        end
        mon_busy = 1'b0;
        prev = tx;
      end else begin
        prev = tx;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int wc;
    int sc;
    bit ok;

    // 1. Reset state
    repeat (3) @(posedge clk);
    #1 check("reset_tx_held", {31'b0, tx}, 32'd1);
    @(negedge clk) reset = 1'b1;
    read_check("reset_status", 32'h0, 32'h0000_0004);
    read_check("reset_ctrl", 32'h8, 32'h0000_0000);
    read_check("reset_dropcnt", 32'hC, 32'h0000_0000);
    check("reset_tx", {31'b0, tx}, 32'd1);

    // 2. Single 0x55 frame with latency check
    starts_q.delete();
    bus_write(32'h8, 32'h1, wc);
    read_check("ctrl_readback", 32'h8, 32'h0000_0001);
    exp_q.push_back(8'h55);
    bus_write(32'h4, 32'h55, wc);
    repeat (40) @(posedge clk);
    read_check("busy_status", 32'h0, 32'h0000_0005);
    read_check("txdata_reads_zero", 32'h4, 32'h0000_0000);
    wait_done(0, 400, "s2_frame_timeout");
    check("s2_start_latency", (starts_q.size() > 0) ? starts_q[0] : -1, wc + 1);
    read_check("s2_status_after", 32'h0, 32'h0000_0004);

    // 3. Fill while disabled, overflow by one
    bus_write(32'h8, 32'h0, wc);
    for (int v = 1; v <= 9; v++) begin
      if (v <= 8) exp_q.push_back(byte'(v));
      bus_write(32'h4, 32'(v), wc);
    end
    repeat (20) @(posedge clk);
    check("s3_tx_idle", {31'b0, tx}, 32'd1);
    read_check("s3_status_full", 32'h0, 32'h0000_0802);
    read_check("s3_dropcnt", 32'hC, 32'h0000_0001);
    bus_write(32'hC, 32'h0, wc);
    read_check("s3_dropcnt_cleared", 32'hC, 32'h0000_0000);

    // 4. Enable: eight back-to-back frames
    starts_q.delete();
    bus_write(32'h8, 32'h1, wc);
    wait_done(0, 2000, "s4_frames_timeout");
    check("s4_frame_count", 32'(starts_q.size()), 32'd8);
    check("s4_first_start", (starts_q.size() > 0) ? starts_q[0] : -1, wc + 1);
    ok = 1'b1;
    for (int i = 1; i < starts_q.size(); i++) begin
      if (starts_q[i] - starts_q[i-1] != 160) ok = 1'b0;
    end
    check("s4_no_gap", {31'b0, ok}, 32'd1);
    read_check("s4_status_after", 32'h0, 32'h0000_0004);

    // 5. Disable mid-frame, then re-enable
    starts_q.delete();
    exp_q.push_back(8'hA5);
    bus_write(32'h4, 32'hA5, wc);
    exp_q.push_back(8'h3C);
    bus_write(32'h4, 32'h3C, wc);
    repeat (50) @(posedge clk);
    bus_write(32'h8, 32'h0, wc);
    wait_done(1, 400, "s5_first_frame_timeout");
    repeat (60) @(posedge clk);
    check("s5_tx_held_high", {31'b0, tx}, 32'd1);
    read_check("s5_status_retained", 32'h0, 32'h0000_0100);
    check("s5_one_frame", 32'(starts_q.size()), 32'd1);
    bus_write(32'h8, 32'h1, wc);
    wait_done(0, 400, "s5_second_frame_timeout");
    read_check("s5_status_after", 32'h0, 32'h0000_0004);

    // 6a. Asynchronous reset during the start bit
    exp_q.push_back(8'hFF);
    bus_write(32'h4, 32'hFF, wc);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("s6_pre_reset_start", {31'b0, tx}, 32'd0);
    #2 reset = 1'b0;
    #1 check("s6_async_tx", {31'b0, tx}, 32'd1);
    exp_q.delete();
    read_check("s6_status_in_reset", 32'h0, 32'h0000_0004);
    @(negedge clk) reset = 1'b1;
    read_check("s6_status_after", 32'h0, 32'h0000_0004);
    read_check("s6_ctrl_after", 32'h8, 32'h0000_0000);

    // 6b. Deselected write must not push
    @(negedge clk);
    busSel = 1'b0; busWe = 1'b1; busAddr = 32'h4; busWData = 32'h77;
    #1 check("s6_rdata_deselected", busRData, 32'h0000_0000);
    @(posedge clk);
    #1 busWe = 1'b0;
    read_check("s6_no_push", 32'h0, 32'h0000_0004);
    bus_write(32'h8, 32'h1, wc);
    sc = starts_q.size();
    repeat (40) @(posedge clk);
    check("s6_no_frame", 32'(starts_q.size()), 32'(sc));
    check("s6_tx_idle", {31'b0, tx}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
